pipeline_hazard_controller: RTL and testbench

- Central sequencing block for the 5-stage MIPS pipeline.
- Generates PC/IF-ID enables, IF-ID flush, ID-EX and MEM-WB bubble controls, and ID-stage forwarding selects.
- Freezes the pipeline on load-use hazards and data-memory wait states.
- Holds the pipe in a bubble-filled state for a fixed number of cycles after reset, and keeps a saturating stall-cycle counter.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/pipeline_hazard_controller_if.sv | 48 ++++
 rtl/forwarding_select.sv | 24 ++
 rtl/pipeline_hazard_controller.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Provides the FSM state encoding, the ID-stage forward-select codes, the
// write-back descriptor of a downstream stage and a register-match helper.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [FWD_W-1:0] FWD_RF       = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EXE      = 2'd1;
  localparam logic [FWD_W-1:0] FWD_MEM_ALU  = 2'd2;
  localparam logic [FWD_W-1:0] FWD_MEM_LOAD = 2'd3;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Write-back view of a downstream stage (EX or MEM).
  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] dest;
  } stage_wb_t;

  // True when the stage will write a non-zero register equal to src.
  function automatic logic reg_hit(input logic [REG_W-1:0] src, input stage_wb_t stg);
    return stg.wreg && (stg.dest != REG_ZERO) && (stg.dest == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives stage info, receives controls).
// slave : controller side (receives stage info, drives controls, status).
interface pipeline_hazard_controller_if #(
  parameter int unsigned CNT_W = 16
);
  import pipeline_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ewreg;
  logic             em2reg;
  logic [REG_W-1:0] edestReg;
  logic             mwreg;
  logic             mm2reg;
  logic [REG_W-1:0] mdestReg;
  logic             branch_taken;
  logic             mem_access;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_bubble;
  logic [FWD_W-1:0] fwda;
  logic [FWD_W-1:0] fwdb;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ewreg, em2reg, edestReg,
           mwreg, mm2reg, mdestReg, branch_taken, mem_access, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble,
           fwda, fwdb, mem_error, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ewreg, em2reg, edestReg,
           mwreg, mm2reg, mdestReg, branch_taken, mem_access, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble,
           fwda, fwdb, mem_error, stall_cycles
  );

endinterface

// File: rtl/forwarding_select.sv
// Combinational ID-operand source select for one source register.
// Ports: src_i (register number), ex_i / mem_i (stage write-back info),
//        fwd_c_o (0 regfile, 1 EX ALU, 2 MEM ALU, 3 MEM load data).
module forwarding_select
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  stage_wb_t        ex_i,
  input  stage_wb_t        mem_i,
  output logic [FWD_W-1:0] fwd_c_o
);

  // Nearest stage wins; an EX load match blocks MEM forwarding and is
  // resolved by the load-use stall instead.
  always_comb begin
    fwd_c_o = FWD_RF;
    if (reg_hit(src_i, ex_i)) begin
      if (!ex_i.m2reg) fwd_c_o = FWD_EXE;
    end else if (reg_hit(src_i, mem_i)) begin
      fwd_c_o = mem_i.m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central sequencing block of the 5-stage MIPS pipeline: post-reset flush,
// load-use and data-memory stalls, branch flush, ID forwarding selects,
// sticky memory-timeout error and a saturating stall-cycle counter.
// Ports: clock, reset (async, active-high), hz (slave side of the bundle).
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned CNT_W        = 16
) (
  input logic                            clock,
  input logic                            reset,
  pipeline_hazard_controller_if.slave    hz
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  stage_wb_t         ex_stg, mem_stg;
  logic [FWD_W-1:0]  fwda_c, fwdb_c, fwda_sel_c, fwdb_sel_c;
  logic              loaduse_c, timeout_c, memstall_c;
  logic              pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c;
  logic              exmem_en_c, memwb_bubble_c;

  assign ex_stg  = '{wreg: hz.ewreg, m2reg: hz.em2reg, dest: hz.edestReg};
  assign mem_stg = '{wreg: hz.mwreg, m2reg: hz.mm2reg, dest: hz.mdestReg};

  forwarding_select u_fwd_rs (.src_i(hz.id_rs), .ex_i(ex_stg), .mem_i(mem_stg), .fwd_c_o(fwda_sel_c));
  forwarding_select u_fwd_rt (.src_i(hz.id_rt), .ex_i(ex_stg), .mem_i(mem_stg), .fwd_c_o(fwdb_sel_c));

  // Load in EX feeding an operand the ID instruction actually reads.
  assign loaduse_c = ex_stg.m2reg &&
                     ((hz.id_uses_rs && reg_hit(hz.id_rs, ex_stg)) ||
                      (hz.id_uses_rt && reg_hit(hz.id_rt, ex_stg)));

  // Next-state and pipeline controls; defaults are the bubble-filled pipe.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_error_d    = mem_error_q;
    stall_d        = stall_q;
    timeout_c      = 1'b0;
    memstall_c     = 1'b0;
    pc_en_c        = 1'b0;
    ifid_en_c      = 1'b0;
    ifid_flush_c   = 1'b1;
    idex_bubble_c  = 1'b1;
    exmem_en_c     = 1'b1;
    memwb_bubble_c = 1'b1;
    fwda_c         = FWD_RF;
    fwdb_c         = FWD_RF;

    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = ST_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FCNT_W'(1);
        end
      end
      default: begin
        timeout_c  = (state_q == ST_MEM_WAIT) && (wait_cnt_q == WAIT_LIMIT);
        memstall_c = hz.mem_access && !hz.dmem_ready && !timeout_c;
        fwda_c     = fwda_sel_c;
        fwdb_c     = fwdb_sel_c;

        if (memstall_c) begin
          // Whole upstream frozen; MEM/WB receives a bubble.
          ifid_flush_c   = 1'b0;
          idex_bubble_c  = 1'b0;
          exmem_en_c     = 1'b0;
        end else if (loaduse_c) begin
          // Hold PC and IF/ID, inject a bubble into EX; branch deferred.
          ifid_flush_c   = 1'b0;
          memwb_bubble_c = 1'b0;
        end else begin
          pc_en_c        = 1'b1;
          ifid_en_c      = 1'b1;
          ifid_flush_c   = hz.branch_taken;
          idex_bubble_c  = 1'b0;
          memwb_bubble_c = 1'b0;
        end

        if (timeout_c) mem_error_d = 1'b1;

        if (memstall_c) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end

        if (!pc_en_c && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_q     <= stall_d;
    end
  end

  assign hz.pc_en        = pc_en_c;
  assign hz.ifid_en      = ifid_en_c;
  assign hz.ifid_flush   = ifid_flush_c;
  assign hz.idex_bubble  = idex_bubble_c;
  assign hz.exmem_en     = exmem_en_c;
  assign hz.memwb_bubble = memwb_bubble_c;
  assign hz.fwda         = fwda_c;
  assign hz.fwdb         = fwdb_c;
  assign hz.mem_error    = mem_error_q;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: flush, load-use, branch,
// forwarding, memory wait/timeout, reset mid-wait, and counter saturation
// on a second 4-bit-counter instance sharing the same inputs.
module tb_pipeline_hazard_controller;

  logic clock;
  logic reset;

  pipeline_hazard_controller_if #(.CNT_W(16)) u_if ();
  pipeline_hazard_controller_if #(.CNT_W(4))  s_if ();

  pipeline_hazard_controller #(.FLUSH_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .hz(u_if.slave)
  );

  pipeline_hazard_controller #(.FLUSH_CYCLES(4), .MEM_TIMEOUT(16), .CNT_W(4)) s_dut (
    .clock(clock), .reset(reset), .hz(s_if.slave)
  );

  assign s_if.id_rs        = u_if.id_rs;
  assign s_if.id_rt        = u_if.id_rt;
  assign s_if.id_uses_rs   = u_if.id_uses_rs;
  assign s_if.id_uses_rt   = u_if.id_uses_rt;
  assign s_if.ewreg        = u_if.ewreg;
  assign s_if.em2reg       = u_if.em2reg;
  assign s_if.edestReg     = u_if.edestReg;
  assign s_if.mwreg        = u_if.mwreg;
  assign s_if.mm2reg       = u_if.mm2reg;
  assign s_if.mdestReg     = u_if.mdestReg;
  assign s_if.branch_taken = u_if.branch_taken;
  assign s_if.mem_access   = u_if.mem_access;
  assign s_if.dmem_ready   = u_if.dmem_ready;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble}
  localparam logic [5:0] CTL_RST = 6'b001111;
  localparam logic [5:0] CTL_LU  = 6'b000110;
  localparam logic [5:0] CTL_RUN = 6'b110010;
  localparam logic [5:0] CTL_BR  = 6'b111010;
  localparam logic [5:0] CTL_MS  = 6'b000001;

  int n_checks;
  int n_fail;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl();
    return 32'({u_if.pc_en, u_if.ifid_en, u_if.ifid_flush,
                u_if.idex_bubble, u_if.exmem_en, u_if.memwb_bubble});
  endfunction

  task automatic clear_inputs();
    u_if.id_rs = '0;       u_if.id_rt = '0;
    u_if.id_uses_rs = 0;   u_if.id_uses_rt = 0;
    u_if.ewreg = 0;        u_if.em2reg = 0;  u_if.edestReg = '0;
    u_if.mwreg = 0;        u_if.mm2reg = 0;  u_if.mdestReg = '0;
    u_if.branch_taken = 0; u_if.mem_access = 0; u_if.dmem_ready = 0;
  endtask

  task automatic set_loaduse_rs8();
    u_if.ewreg = 1; u_if.em2reg = 1; u_if.edestReg = 5'd8;
    u_if.id_rs = 5'd8; u_if.id_uses_rs = 1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    clear_inputs();
    #1;
    check_eq("rst_ctl", ctl(), 32'(CTL_RST));
    check_eq("rst_fwda", 32'(u_if.fwda), 0);
    check_eq("rst_stall", 32'(u_if.stall_cycles), 0);
    check_eq("rst_err", 32'(u_if.mem_error), 0);

    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("flush_ctl", ctl(), 32'(CTL_RST));
      @(negedge clock);
    end
    #1;
    check_eq("run_ctl", ctl(), 32'(CTL_RUN));
    check_eq("run_stall", 32'(u_if.stall_cycles), 0);

    // Load-use on rs with a taken branch: stall wins, branch ignored
    @(negedge clock);
    set_loaduse_rs8(); u_if.branch_taken = 1;
    #1;
    check_eq("lu_ctl", ctl(), 32'(CTL_LU));
    check_eq("lu_fwda", 32'(u_if.fwda), 0);

    // Load has moved into MEM: forward load data
    @(negedge clock);
    clear_inputs();
    u_if.mwreg = 1; u_if.mm2reg = 1; u_if.mdestReg = 5'd8;
    u_if.id_rs = 5'd8; u_if.id_uses_rs = 1;
    #1;
    check_eq("lu_next_fwda", 32'(u_if.fwda), 3);
    check_eq("lu_next_ctl", ctl(), 32'(CTL_RUN));
    check_eq("lu_stall", 32'(u_if.stall_cycles), 1);

    @(negedge clock);
    u_if.branch_taken = 1;
    #1 check_eq("br_ctl", ctl(), 32'(CTL_BR));

    // Forwarding priority on rt
    @(negedge clock);
    clear_inputs();
    u_if.ewreg = 1; u_if.mwreg = 1; u_if.edestReg = 5'd5; u_if.mdestReg = 5'd5;
    u_if.id_rt = 5'd5; u_if.id_uses_rt = 1;
    #1;
    check_eq("fwdb_ex", 32'(u_if.fwdb), 1);
    check_eq("fwda_none", 32'(u_if.fwda), 0);

    @(negedge clock);
    u_if.ewreg = 0;
    #1 check_eq("fwdb_mem_alu", 32'(u_if.fwdb), 2);

    @(negedge clock);
    u_if.ewreg = 1; u_if.edestReg = 5'd0; u_if.mdestReg = 5'd0; u_if.id_rt = 5'd0;
    #1 check_eq("fwdb_r0", 32'(u_if.fwdb), 0);

    // EX load match blocks MEM ALU forwarding; unused operand gives no stall
    @(negedge clock);
    clear_inputs();
    u_if.ewreg = 1; u_if.em2reg = 1; u_if.edestReg = 5'd9;
    u_if.mwreg = 1; u_if.mm2reg = 0; u_if.mdestReg = 5'd9;
    u_if.id_rs = 5'd9; u_if.id_uses_rs = 0;
    #1;
    check_eq("fwda_exload", 32'(u_if.fwda), 0);
    check_eq("nouse_ctl", ctl(), 32'(CTL_RUN));

    @(negedge clock);
    u_if.id_rt = 5'd9; u_if.id_uses_rt = 1;
    #1 check_eq("lu_rt_ctl", ctl(), 32'(CTL_LU));

    // Load to r0 never stalls
    @(negedge clock);
    clear_inputs();
    u_if.ewreg = 1; u_if.em2reg = 1; u_if.edestReg = 5'd0; u_if.id_uses_rs = 1;
    #1;
    check_eq("lu_r0_ctl", ctl(), 32'(CTL_RUN));
    check_eq("stall_2", 32'(u_if.stall_cycles), 2);

    // Three wait cycles then ready
    @(negedge clock);
    clear_inputs();
    u_if.mem_access = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("mw_ctl", ctl(), 32'(CTL_MS));
      @(negedge clock);
    end
    u_if.dmem_ready = 1;
    #1;
    check_eq("mw_rel_ctl", ctl(), 32'(CTL_RUN));
    check_eq("mw_stall", 32'(u_if.stall_cycles), 5);
    check_eq("mw_stall_small", 32'(s_if.stall_cycles), 5);
    check_eq("mw_err", 32'(u_if.mem_error), 0);

    // Ready in the same cycle: no stall at all
    @(negedge clock);
    #1 check_eq("mw_zero_ctl", ctl(), 32'(CTL_RUN));
    @(negedge clock);
    u_if.mem_access = 0; u_if.dmem_ready = 0;
    #1 check_eq("mw_zero_stall", 32'(u_if.stall_cycles), 5);

    // Memory stall outranks load-use; load-use then applies on release
    @(negedge clock);
    set_loaduse_rs8(); u_if.mem_access = 1;
    #1 check_eq("ms_over_lu", ctl(), 32'(CTL_MS));
    @(negedge clock);
    u_if.dmem_ready = 1;
    #1 check_eq("lu_after_ms", ctl(), 32'(CTL_LU));
    @(negedge clock);
    clear_inputs();
    #1 check_eq("stall_7", 32'(u_if.stall_cycles), 7);

    // Timeout: 16 stalled cycles, forced release on the 17th
    @(negedge clock);
    u_if.mem_access = 1;
    for (int i = 0; i < 16; i++) begin
      #1 check_eq("to_wait_ctl", ctl(), 32'(CTL_MS));
      @(negedge clock);
    end
    #1;
    check_eq("to_rel_ctl", ctl(), 32'(CTL_RUN));
    check_eq("to_err_pre", 32'(u_if.mem_error), 0);
    @(negedge clock);
    u_if.mem_access = 0;
    #1;
    check_eq("to_err", 32'(u_if.mem_error), 1);
    check_eq("to_stall", 32'(u_if.stall_cycles), 23);
    check_eq("sat_stall", 32'(s_if.stall_cycles), 15);
    @(negedge clock);
    #1;
    check_eq("to_err_sticky", 32'(u_if.mem_error), 1);
    check_eq("sat_hold", 32'(s_if.stall_cycles), 15);

    // Reset in the middle of a wait
    @(negedge clock);
    u_if.mem_access = 1;
    u_if.ewreg = 1; u_if.edestReg = 5'd3; u_if.id_rs = 5'd3;
    #1 check_eq("rw_ctl0", ctl(), 32'(CTL_MS));
    check_eq("rw_fwda_run", 32'(u_if.fwda), 1);
    @(negedge clock);
    #1 check_eq("rw_ctl1", ctl(), 32'(CTL_MS));
    #2 reset = 1'b1;
    #1;
    check_eq("rw_rst_ctl", ctl(), 32'(CTL_RST));
    check_eq("rw_rst_fwda", 32'(u_if.fwda), 0);
    check_eq("rw_rst_err", 32'(u_if.mem_error), 0);
    check_eq("rw_rst_stall", 32'(u_if.stall_cycles), 0);

    @(negedge clock);
    reset = 1'b0;
    u_if.mem_access = 0;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("rw_flush_ctl", ctl(), 32'(CTL_RST));
      check_eq("rw_flush_fwda", 32'(u_if.fwda), 0);
      @(negedge clock);
    end
    #1;
    check_eq("rw_run_ctl", ctl(), 32'(CTL_RUN));
    check_eq("rw_run_fwda", 32'(u_if.fwda), 1);
    check_eq("rw_run_stall", 32'(u_if.stall_cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
